// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter and its stimulus generator.
// Contents: FSM state encodings, line levels for the frame, generator
// timing, and the 8-bit LFSR step used to produce test payloads.
package uart_pkg;

  // Transmitter FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Frame line levels
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;

  // Stimulus generator timing and payload sequence
  localparam int         GEN_PERIOD      = 20;
  localparam int         GEN_FIRST_DELAY = 5;
  localparam logic [7:0] LFSR_SEED       = 8'hA5;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting left
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/transmitter_gen.sv
// Stimulus generator for uart_transmitter.
// Ports:
//   tx_clk   in   clock
//   rst_n    in   async active-low reset
//   enable   out  registered one-cycle send request, every GEN_PERIOD cycles
//   data_in  out  registered payload from an 8-bit LFSR, advanced after each pulse
module transmitter_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  output logic                  enable,
  output logic [DATA_WIDTH-1:0] data_in
);

  logic [4:0] gap_cnt;
  logic [7:0] lfsr_q;

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      enable  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      gap_cnt <= 5'(GEN_FIRST_DELAY - 1);
    end else begin
      // The consumer samples data_in together with enable, so advance only
      // on the edge after the pulse.
      if (enable) lfsr_q <= lfsr8_next(lfsr_q);
      if (gap_cnt == 5'd0) begin
        enable  <= 1'b1;
        gap_cnt <= 5'(GEN_PERIOD - 1);
      end else begin
        enable  <= 1'b0;
        gap_cnt <= gap_cnt - 5'd1;
      end
    end
  end

  assign data_in = DATA_WIDTH'(lfsr_q);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
// Ports:
//   tx_clk   in   clock (baud clock when CLKS_PER_BIT = 1)
//   rst_n    in   async active-low reset
//   data_in  in   parallel word, captured only when a request is accepted
//   enable   in   send request, honoured only in IDLE
//   tx_out   out  registered serial line, idle high
//
// state | meaning
// IDLE  | line high, waiting for enable
// START | driving start bit
// DATA  | driving shift-register bit 0, shifting once per bit period
// STOP  | driving stop bit, then back to IDLE
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable,
  output logic                  tx_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0]      clk_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_done;
  logic                  last_bit;

  assign bit_done  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign shreg_nxt = shreg >> 1;

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_out  <= LINE_IDLE;
      shreg   <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_out  <= LINE_IDLE;
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (enable) begin
            shreg  <= data_in;
            state  <= START;
            tx_out <= START_BIT;
          end
        end
        START: begin
          if (bit_done) begin
            clk_cnt <= '0;
            state   <= DATA;
            tx_out  <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            shreg   <= shreg_nxt;
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= STOP;
              tx_out  <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // Drive the next bit from the same edge the register shifts.
              tx_out  <= shreg_nxt[0];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  logic       tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic       rst_n, rst4_n, rstg_n;
  logic [7:0] data_in, data4;
  logic       enable, enable4;
  logic       tx_out, tx4;
  logic       gen_en;
  logic [7:0] gen_data;
  logic       gen_tx;

  int checks   = 0;
  int failures = 0;

  uart_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .data_in(data_in), .enable(enable), .tx_out(tx_out));

  uart_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
    .tx_clk(tx_clk), .rst_n(rst4_n), .data_in(data4), .enable(enable4), .tx_out(tx4));

  transmitter_gen #(.DATA_WIDTH(8)) u_gen (
    .tx_clk(tx_clk), .rst_n(rstg_n), .enable(gen_en), .data_in(gen_data));

  uart_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut_gen (
    .tx_clk(tx_clk), .rst_n(rstg_n), .data_in(gen_data), .enable(gen_en), .tx_out(gen_tx));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for position i of a 10-bit frame
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return d[i-1];
  endfunction

  // Called at a negedge. Requests a frame, checks all 10 bits on the main
  // DUT, then the idle cycle after. enable is re-driven high for samples in
  // [en_from, en_to]; data_in is scrambled during the frame.
  task automatic send_chk(input logic [7:0] d, input string tag,
                          input int en_from, input int en_to);
    data_in = d;
    enable  = 1'b1;
    @(negedge tx_clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s bit%0d", tag, i), {31'd0, tx_out}, {31'd0, frame_bit(d, i)});
      enable  = (i >= en_from && i <= en_to);
      data_in = ~d;
      @(negedge tx_clk);
    end
    enable = 1'b0;
    chk($sformatf("%s idle", tag), {31'd0, tx_out}, 32'd1);
  endtask

  logic [7:0] exp_lfsr;
  logic [7:0] rx_data;
  int         rx_bit;
  bit         in_frame;
  int         frames;

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; rstg_n = 1'b0;
    data_in = 8'h00; data4 = 8'h00;
    enable = 1'b0; enable4 = 1'b0;
    repeat (2) @(negedge tx_clk);

    chk("rst tx_out",   {31'd0, tx_out}, 32'd1);
    chk("rst tx4",      {31'd0, tx4},    32'd1);
    chk("rst gen_tx",   {31'd0, gen_tx}, 32'd1);
    chk("rst gen_en",   {31'd0, gen_en}, 32'd0);
    chk("rst gen_data", {24'd0, gen_data}, 32'h0000_00A5);

    rst_n  = 1'b1;
    rst4_n = 1'b1;

    // First enable after reset release is accepted on the next edge
    send_chk(8'hA5, "a5", -1, -1);
    send_chk(8'h00, "x00", -1, -1);
    send_chk(8'hFF, "xff", -1, -1);

    // Second request mid-frame is ignored, nothing queued
    send_chk(8'h5A, "mid_en", 2, 2);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("mid_en quiet%0d", i), {31'd0, tx_out}, 32'd1);
      @(negedge tx_clk);
    end

    // enable held high for several cycles starts a single frame
    send_chk(8'h81, "held_en", 0, 4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_en quiet%0d", i), {31'd0, tx_out}, 32'd1);
      @(negedge tx_clk);
    end

    // Async reset during data bit 4 aborts the frame
    data_in = 8'h2C;
    enable  = 1'b1;
    @(negedge tx_clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abort bit%0d", i), {31'd0, tx_out}, {31'd0, frame_bit(8'h2C, i)});
      @(negedge tx_clk);
    end
    chk("abort bit5 pre", {31'd0, tx_out}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("abort async high", {31'd0, tx_out}, 32'd1);
    #1 rst_n = 1'b1;
    @(negedge tx_clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort quiet%0d", i), {31'd0, tx_out}, 32'd1);
      @(negedge tx_clk);
    end
    send_chk(8'hC3, "post_rst", -1, -1);

    // CLKS_PER_BIT = 4: each bit held four cycles, 40-cycle frame
    data4   = 8'h3C;
    enable4 = 1'b1;
    @(negedge tx_clk);
    enable4 = 1'b0;
    data4   = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("cpb4 s%0d", i), {31'd0, tx4}, {31'd0, frame_bit(8'h3C, i / 4)});
      @(negedge tx_clk);
    end
    chk("cpb4 idle", {31'd0, tx4}, 32'd1);

    // Generator driving a transmitter: decode frames off the line
    exp_lfsr = 8'hA5;
    rx_data  = 8'h00;
    rx_bit   = 0;
    in_frame = 1'b0;
    frames   = 0;
    rstg_n   = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge tx_clk);
      if (!in_frame) begin
        if (gen_tx == 1'b0) begin
          in_frame = 1'b1;
          rx_bit   = 0;
        end
      end else begin
        rx_bit++;
        if (rx_bit <= 8) begin
          rx_data[rx_bit-1] = gen_tx;
        end else begin
          chk($sformatf("gen f%0d stop", frames), {31'd0, gen_tx}, 32'd1);
          chk($sformatf("gen f%0d data", frames), {24'd0, rx_data}, {24'd0, exp_lfsr});
          exp_lfsr = {exp_lfsr[6:0], exp_lfsr[7] ^ exp_lfsr[5] ^ exp_lfsr[4] ^ exp_lfsr[3]};
          frames++;
          in_frame = 1'b0;
        end
      end
    end
    chk("gen frame count", 32'(frames), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 1, number of tx_clk cycles per serial bit (tx_clk is the baud clock at default).
REQ-003 tx_clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  DATA_WIDTH  parallel byte to send; sampled only on an accepted enable.
REQ-006 enable  input  1  one-cycle send request, sampled on rising tx_clk.
REQ-007 tx_out  output  1  serial line, registered, idle high.
REQ-008 Port order SHALL be tx_clk, rst_n, data_in, enable, tx_out, so positional instantiation works.

Function
REQ-009 Frame SHALL be: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1); no parity.
REQ-010 Each bit SHALL hold tx_out for exactly CLKS_PER_BIT tx_clk cycles.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE: tx_out=1; on a rising edge with enable=1, latch data_in into a shift register, go to START, drive tx_out=0 from that same edge.
REQ-013 START -> DATA after CLKS_PER_BIT cycles; DATA drives shift-register bit 0 and shifts right once per bit period.
REQ-014 DATA -> STOP after DATA_WIDTH bit periods, counted by a bit counter 0..DATA_WIDTH-1; STOP drives tx_out=1.
REQ-015 STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-016 Latency: the start bit SHALL appear on the first edge after enable is sampled; the frame SHALL occupy (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-017 enable outside IDLE SHALL be ignored; no queuing. data_in changes during a frame SHALL NOT affect the frame in flight.
REQ-018 enable held high across multiple cycles SHALL start one frame; another frame starts only when enable is seen in IDLE again. At default parameters, the minimum accepted enable spacing is 11 cycles.
REQ-019 The bit-period counter width SHALL be $clog2(CLKS_PER_BIT)+1, and it SHALL wrap to 0 at every bit boundary.

Reset
REQ-020 rst_n low SHALL immediately force state=IDLE, tx_out=1, and the shift register and counters to 0, regardless of the clock.
REQ-021 Reset asserted mid-frame SHALL abort the frame, with the line returning high with no stop bit.
REQ-022 After rst_n rises, the first enable SHALL be accepted on the next rising edge.

Structure
REQ-023 State encoding localparams (IDLE/START/DATA/STOP) and frame constants SHALL reside in a shared package uart_pkg.
REQ-024 uart_transmitter SHALL contain no sub-modules.
REQ-025 A companion stimulus module transmitter_gen SHALL be provided (the one natural extra module), with ports:
- tx_clk, rst_n inputs;
- enable, data_in[DATA_WIDTH-1:0] outputs, both registered.
REQ-026 transmitter_gen behaviour:
- pulses enable for exactly one cycle every 20 cycles;
- first pulse comes 5 cycles after reset release;
- data_in is an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 0xA5) advanced after each pulse;
- reset drives enable=0 and data_in=seed.

Verification
REQ-027 Reset then enable=1 with data_in=0xA5 for one cycle -> tx_out on successive cycles 0,1,0,1,0,0,1,0,1,1, then idle high.
REQ-028 data_in=0x00 then 0xFF -> start 0, eight 0s, stop 1; then start 0, eight 1s, stop 1; each frame 10 cycles.
REQ-029 Second enable 3 cycles after the first (mid-frame) -> ignored; tx_out carries only the first frame, then stays 1.
REQ-030 rst_n pulsed low asynchronously during data bit 4 -> tx_out=1 within the same cycle; next enable sends a complete fresh frame.
REQ-031 CLKS_PER_BIT=4 with data 0x3C -> each bit held 4 cycles; frame length 40 cycles.
REQ-032 transmitter_gen connected to uart_transmitter for 200 cycles after reset -> 10 complete well-formed frames, with data matching the LFSR sequence starting at 0xA5.
